// File: rtl/div_unit.sv
// Multicycle signed 32-bit divider (truncating, remainder follows dividend sign).
// One restoring step per cycle; results land in hi_out/lo_out with a one-cycle done pulse.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_busy,
    output logic        div_done,
    output logic        div_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_sign_q;
    logic        r_sign_r;
    logic [31:0] r_quot;
    logic [31:0] r_div;
    logic [31:0] r_rem;
    logic [4:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_zero;

    logic        w_accept;
    logic        w_zero_req;
    logic        w_last;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_trial_ok;

    assign w_accept   = (r_state == StIdle) && div_start && (data_b != 32'd0);
    assign w_zero_req = (r_state == StIdle) && div_start && (data_b == 32'd0);
    assign w_last     = (r_count == 5'd31);
    assign w_abs_a    = data_a[31] ? (~data_a + 32'd1) : data_a;
    assign w_abs_b    = data_b[31] ? (~data_b + 32'd1) : data_b;

    // Shifted remainder is below 2*divisor, so trial difference fits 33-bit signed.
    assign w_shift    = {r_rem, r_quot[31]};
    assign w_trial    = w_shift - {1'b0, r_div};
    assign w_trial_ok = ~w_trial[32];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (w_accept) w_state_next = StRun;
            StRun:    if (w_last) w_state_next = StFinish;
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        div_busy = (r_state != StIdle);
        div_done = r_done;
        div_zero = r_zero;
        hi_out   = r_hi;
        lo_out   = r_lo;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_quot   <= 32'd0;
            r_div    <= 32'd0;
            r_rem    <= 32'd0;
            r_count  <= 5'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_zero <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_sign_q <= data_a[31] ^ data_b[31];
                        r_sign_r <= data_a[31];
                        r_quot   <= w_abs_a;
                        r_div    <= w_abs_b;
                        r_rem    <= 32'd0;
                        r_count  <= 5'd0;
                    end else if (w_zero_req) begin
                        r_zero <= 1'b1;
                    end
                end
                StRun: begin
                    r_rem   <= w_trial_ok ? w_trial[31:0] : w_shift[31:0];
                    r_quot  <= {r_quot[30:0], w_trial_ok};
                    r_count <= r_count + 5'd1;
                end
                StFinish: begin
                    r_lo   <= r_sign_q ? (~r_quot + 32'd1) : r_quot;
                    r_hi   <= r_sign_r ? (~r_rem + 32'd1) : r_rem;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table plus scoreboard queue popped on each div_done,
// with hand sequences for divide-by-zero, mid-operation reset and start-while-busy.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_start;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_busy;
    logic        div_done;
    logic        div_zero;

    always #5 clk = ~clk;

    div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .data_a    (data_a),
        .data_b    (data_b),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .div_zero  (div_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    vec_t vecs[12];
    res_t sb_q[$];
    res_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset === 1'b1 && div_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done with hi=%h lo=%h expected none",
                         hi_out, lo_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("hi_out", hi_out, mon_e.hi);
                check("lo_out", lo_out, mon_e.lo);
            end
            check("done_zero_excl", {31'd0, div_zero}, 32'd0);
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        res_t r;
        r.hi = exp_hi;
        r.lo = exp_lo;
        sb_q.push_back(r);
        data_a    = a;
        data_b    = b;
        div_start = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the start edge; scrambles operands to prove they are not re-sampled.
    task automatic wait_done(input int inject, output int done_at, output int busy_cnt);
        done_at  = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                div_start = 1'b0;
                data_a    = $urandom;
                data_b    = $urandom;
            end
            if (i == inject) begin
                div_start = 1'b1;
                data_a    = 32'd9;
                data_b    = 32'd3;
            end
            if (i == inject + 1) div_start = 1'b0;
            if (div_done) begin
                done_at = i;
                break;
            end
            if (div_busy) busy_cnt++;
        end
    endtask

    initial begin
        int  d;
        int  b;
        logic seen;

        vecs[0]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[1]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2};
        vecs[2]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vecs[3]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        vecs[4]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
        vecs[5]  = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
        vecs[6]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF};
        vecs[7]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0};
        vecs[8]  = '{32'd0,        32'd5,        32'd0,        32'd0};
        vecs[9]  = '{32'd12345,    32'd12345,    32'd1,        32'd0};
        vecs[10] = '{32'd5,        32'd7,        32'd0,        32'd5};
        vecs[11] = '{32'd7,        32'd2,        32'd3,        32'd1};

        reset     = 1'b0;
        div_start = 1'b0;
        data_a    = 32'd0;
        data_b    = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_done", {31'd0, div_done}, 32'd0);
        check("rst_zero", {31'd0, div_zero}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            wait_done(0, d, b);
            check("done_latency", d, 32'd34);
            check("busy_cycles", b, 32'd33);
            @(negedge clk);
            check("done_single_pulse", {31'd0, div_done}, 32'd0);
        end

        // Divide by zero after 7/2 left hi=1, lo=3.
        data_a    = 32'd5;
        data_b    = 32'd0;
        div_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        check("zero_pulse", {31'd0, div_zero}, 32'd1);
        check("zero_busy", {31'd0, div_busy}, 32'd0);
        @(negedge clk);
        check("zero_falls", {31'd0, div_zero}, 32'd0);
        check("zero_busy2", {31'd0, div_busy}, 32'd0);
        check("zero_hold_hi", hi_out, 32'd1);
        check("zero_hold_lo", lo_out, 32'd3);
        repeat (3) @(negedge clk);

        // Reset in the middle of 1000/3: no result is expected.
        data_a    = 32'd1000;
        data_b    = 32'd3;
        div_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy_before", {31'd0, div_busy}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {31'd0, div_busy}, 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | div_done;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);

        // Start while busy is ignored; a start in the done cycle is accepted.
        launch(32'd20, 32'd4, 32'd0, 32'd5);
        wait_done(5, d, b);
        check("busy_start_latency", d, 32'd34);
        launch(32'd9, 32'd3, 32'd0, 32'd3);
        wait_done(0, d, b);
        check("b2b_latency", d, 32'd34);
        check("b2b_busy", b, 32'd33);
        @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
